// File: rtl/fetch_phase_pkg.sv
// Shared fetch-stage types and constants. The fetch_phase top can be built with the
// FETCH_MISALIGN_TRAP_EN macro, which turns misaligned redirect targets into a sticky fault.
package fetch_phase_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST           = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO used by the fetch stage for both the instruction queue and the
// issued-address tag queue. DEPTH must be a power of two and at least 2.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop.
  always_comb begin
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_phase.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited pipelined imem reads,
// queues returned words for decode and drops stale responses after a redirect.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky fault.
module fetch_phase
  import fetch_phase_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   q_count, tag_count;
  logic            q_empty, q_full, tag_empty, tag_full;
  fetch_entry_t    q_head, q_wdata;
  logic [XLEN-1:0] tag_head;
  logic            fault, credit_ok, issue, rsp_valid, q_push, q_pop;

  // Every in-flight read owns a queue slot, so a response can never find the queue full.
  assign credit_ok   = ({1'b0, outstanding_q} + {1'b0, q_count}) < (CW+1)'(FIFO_DEPTH);
  assign o_imem_req  = i_rst_n && credit_ok && !i_redirect && !fault;
  assign o_imem_addr = pc_q;
  assign issue       = o_imem_req && i_imem_gnt;
  assign rsp_valid   = i_imem_rvalid && (outstanding_q != '0);
  assign q_push      = rsp_valid && (discard_q == '0) && !i_redirect;
  assign q_pop       = o_inst_valid && i_inst_ready;
  assign q_wdata     = '{pc: tag_head, inst: i_imem_rdata};

  assign o_inst_valid = !q_empty;
  assign o_inst       = q_empty ? NOP_INST : q_head.inst;

  always_comb begin
    pc_d = pc_q;
    if (i_redirect)  pc_d = align_pc(i_redirect_pc);
    else if (issue)  pc_d = pc_q + XLEN'(INST_BYTES);
    outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_valid);
    discard_d     = discard_q;
    if (i_redirect)                        discard_d = outstanding_q - CW'(rsp_valid);
    else if (rsp_valid && discard_q != '0) discard_d = discard_q - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  always_comb begin
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (i_redirect) begin
      fault_d    = |i_redirect_pc[1:0];
      fault_pc_d = i_redirect_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign fault     = fault_q;
  assign o_inst_pc = fault_q ? fault_pc_q : q_head.pc;
`else
  assign fault     = 1'b0;
  assign o_inst_pc = q_head.pc;
`endif

  assign o_fetch_fault = fault;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*XLEN)) u_inst_q (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (i_redirect),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_head),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  // Tags are never flushed: stale responses still consume their tag as they drain.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_tag_q (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (1'b0),
    .push  (issue),
    .wdata (pc_q),
    .pop   (rsp_valid),
    .rdata (tag_head),
    .empty (tag_empty),
    .full  (tag_full),
    .count (tag_count)
  );

  a_tag_tracks_outstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    tag_count == outstanding_q);
  a_no_tag_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(tag_full && issue));
  a_rsp_has_tag: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    rsp_valid |-> !tag_empty);
  a_no_queue_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(q_full && q_push && !q_pop));

endmodule

// File: tb/tb_fetch_phase.sv
// Scoreboard bench for fetch_phase: an imem model answers grants, expected PCs are queued
// by the directed tests, and a monitor checks every word decode accepts.
module tb_fetch_phase;

  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;
  logic        o_fetch_fault;

  always #5 i_clk = ~i_clk;

  fetch_phase #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_inst_ready  (i_inst_ready),
    .o_fetch_fault (o_fetch_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  rsp_t        pending[$];
  logic [31:0] exp_pc[$];
  logic [31:0] issued[$];
  int          issue_count = 0;
  int          first_issue_cyc = -1;
  int          first_valid_cyc = -1;
  bit          gnt_en = 1'b0;
  int          rsp_delay = 1;
  bit          redir_req = 1'b0;
  bit          redir_done = 1'b0;
  int          redir_mode = 0;
  logic [31:0] redir_target = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Imem model plus decode-ready and redirect drivers; all inputs change on the falling edge.
  always @(negedge i_clk) begin
    bit   rv;
    bit   fire;
    rsp_t r;
    rv = 1'b0;
    i_imem_gnt = gnt_en;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      rv = 1'b1;
      i_imem_rdata = inst_of(pending[0].addr);
      void'(pending.pop_front());
    end
    i_imem_rvalid = rv;
    i_inst_ready  = (exp_pc.size() > 0);
    fire = 1'b0;
    if (redir_req) begin
      case (redir_mode)
        1:       fire = rv && o_inst_valid && i_inst_ready;
        2:       fire = rv && !o_inst_valid && (pending.size() > 0);
        default: fire = 1'b1;
      endcase
    end
    i_redirect = fire;
    if (fire) begin
      i_redirect_pc = redir_target;
      redir_req  = 1'b0;
      redir_done = 1'b1;
    end
    #1;
    if (o_imem_req && i_imem_gnt) begin
      r.addr = o_imem_addr;
      r.due  = cyc + rsp_delay;
      pending.push_back(r);
      issued.push_back(o_imem_addr);
      issue_count++;
      if (first_issue_cyc < 0) first_issue_cyc = cyc;
    end
  end

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge i_clk) begin
    logic [31:0] e;
    #2;
    if (i_rst_n && o_inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_inst_valid && i_inst_ready) begin
      if (exp_pc.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_pop: got pc %h, expected no delivery", o_inst_pc);
      end else begin
        e = exp_pc.pop_front();
        check("inst_pc", o_inst_pc, e);
        check("inst_word", o_inst, inst_of(e));
      end
    end
  end

  task automatic do_redirect(input logic [31:0] target, input int mode);
    redir_target = target;
    redir_mode   = mode;
    redir_done   = 1'b0;
    redir_req    = 1'b1;
    for (int i = 0; i < 40 && !redir_done; i++) @(posedge i_clk);
    tests_run++;
    if (!redir_done) begin
      tests_failed++;
      redir_req = 1'b0;
      $display("[TB] FAIL redirect_trigger: target %h mode %0d never fired, expected within 40 cycles", target, mode);
    end
  endtask

  task automatic quiesce;
    gnt_en = 1'b0;
    @(posedge i_clk);
    for (int i = 0; i < 40 && pending.size() > 0; i++) @(posedge i_clk);
    @(posedge i_clk);
  endtask

  task automatic wait_pending(input int n);
    for (int i = 0; i < 40 && pending.size() < n; i++) @(posedge i_clk);
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 80 && exp_pc.size() > 0; i++) @(posedge i_clk);
    check(name, exp_pc.size(), 0);
    exp_pc.delete();
  endtask

  task automatic sample_point;
    @(negedge i_clk);
    #3;
  endtask

  initial begin
    bit seen;
    int snap;

    // Reset state
    gnt_en = 1'b1;
    rsp_delay = 1;
    sample_point();
    check("rst_req", o_imem_req, 0);
    check("rst_valid", o_inst_valid, 0);
    check("rst_fault", o_fetch_fault, 0);
    check("rst_addr", o_imem_addr, 32'h0);

    // 1: streaming from reset
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_drained("t1_stream_drained");
    check("t1_first_addr", (issued.size() > 0) ? issued[0] : 32'hDEAD_BEEF, 32'h0);
    check("t1_fill_latency", first_valid_cyc - first_issue_cyc, 2);

    // 2: decode stalled, credit stops issue at DEPTH
    quiesce();
    do_redirect(32'h40, 0);
    issue_count = 0;
    rsp_delay = 1;
    gnt_en = 1'b1;
    repeat (5) @(posedge i_clk);
    sample_point();
    check("t2_issued", issue_count, DEPTH);
    check("t2_req_low", o_imem_req, 0);
    exp_pc = '{32'h40, 32'h44, 32'h48, 32'h4C};
    wait_drained("t2_drained");

    // 3: redirect with two reads in flight
    quiesce();
    do_redirect(32'h80, 0);
    rsp_delay = 6;
    gnt_en = 1'b1;
    wait_pending(2);
    do_redirect(32'h100, 0);
    rsp_delay = 1;
    exp_pc = '{32'h100, 32'h104};
    wait_drained("t3_drained");

    // 4a: redirect coinciding with rvalid and a decode pop
    quiesce();
    do_redirect(32'h300, 0);
    rsp_delay = 1;
    exp_pc = '{32'h300};
    gnt_en = 1'b1;
    do_redirect(32'h400, 1);
    check("t4_pop_in_redirect", exp_pc.size(), 0);
    exp_pc = '{32'h400, 32'h404};
    wait_drained("t4a_drained");

    // 4b: redirect coinciding with rvalid, one more stale read behind it
    quiesce();
    do_redirect(32'h500, 0);
    rsp_delay = 2;
    gnt_en = 1'b1;
    do_redirect(32'h600, 2);
    exp_pc = '{32'h600, 32'h604};
    wait_drained("t4b_drained");

    // 5: PC wrap, and req/addr stable without grant
    quiesce();
    do_redirect(32'hFFFF_FFFC, 0);
    sample_point();
    check("t5_req_wait", o_imem_req, 1);
    check("t5_addr_wait", o_imem_addr, 32'hFFFF_FFFC);
    sample_point();
    check("t5_addr_stable", o_imem_addr, 32'hFFFF_FFFC);
    issued.delete();
    gnt_en = 1'b1;
    exp_pc = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    wait_drained("t5_drained");
    check("t5_wrap_addr", (issued.size() > 1) ? issued[1] : 32'hDEAD_BEEF, 32'h0);

    // 6: misaligned redirect target
    quiesce();
    do_redirect(32'h102, 0);
    gnt_en = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    sample_point();
    check("t6_fault_set", o_fetch_fault, 1);
    check("t6_req_blocked", o_imem_req, 0);
    check("t6_fault_pc", o_inst_pc, 32'h102);
    snap = issue_count;
    repeat (3) @(posedge i_clk);
    check("t6_no_issue", issue_count - snap, 0);
    do_redirect(32'h200, 0);
    sample_point();
    check("t6_fault_clear", o_fetch_fault, 0);
    exp_pc = '{32'h200, 32'h204};
`else
    sample_point();
    check("t6_no_fault", o_fetch_fault, 0);
    exp_pc = '{32'h100, 32'h104};
`endif
    wait_drained("t6_drained");

    // 7: reset mid-transfer, late responses ignored
    quiesce();
    do_redirect(32'h700, 0);
    rsp_delay = 4;
    gnt_en = 1'b1;
    wait_pending(2);
    gnt_en = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    sample_point();
    check("t7_req_in_reset", o_imem_req, 0);
    check("t7_addr_reset", o_imem_addr, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_point();
      seen |= o_inst_valid;
    end
    check("t7_late_rsp_ignored", seen, 0);
    for (int i = 0; i < 20 && pending.size() > 0; i++) @(posedge i_clk);
    rsp_delay = 1;
    gnt_en = 1'b1;
    exp_pc = '{32'h0, 32'h4};
    wait_drained("t7_drained");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
